baccarat_round_ctrl: RTL

BACCARAT_ROUND_CTRL -- requirements
Module: baccarat_round_ctrl

---
 rtl/baccarat_round_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/baccarat_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : baccarat_round_ctrl
// Description : Round sequencer for a baccarat table. It strobes card loads
//               into an external datapath, applies the third-card drawing
//               rules, latches the round result into two lights, and keeps
//               saturating win/tie tallies.
// Ports       : slow_clock            - sole clock (rising edge)
//               reset                 - asynchronous active-high reset
//               start                 - new-round request, honoured in IDLE
//               pscore, dscore        - current player/dealer scores (mod 10)
//               pcard3                - player third-card value
//               load_pcard1..3,
//               load_dcard1..3        - one-cycle card-load strobes
//               player_win_light,
//               dealer_win_light      - result lights (both high = tie)
//               busy                  - high whenever not IDLE
//               done                  - pulse on the last HOLD cycle
//               player_wins,
//               dealer_wins, ties     - saturating round tallies
// Revision    : 1.0 - initial release
// ============================================================================
module baccarat_round_ctrl #(
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int AUTO_REPLAY = 0
) (
    input  logic             slow_clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       pscore,
    input  logic [3:0]       dscore,
    input  logic [3:0]       pcard3,
    output logic             load_pcard1,
    output logic             load_pcard2,
    output logic             load_pcard3,
    output logic             load_dcard1,
    output logic             load_dcard2,
    output logic             load_dcard3,
    output logic             player_win_light,
    output logic             dealer_win_light,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] player_wins,
    output logic [CNT_W-1:0] dealer_wins,
    output logic [CNT_W-1:0] ties
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_PC1    = 4'd1,
        S_DC1    = 4'd2,
        S_PC2    = 4'd3,
        S_DC2    = 4'd4,
        S_NAT    = 4'd5,
        S_PC3    = 4'd6,
        S_BCHK   = 4'd7,
        S_DC3    = 4'd8,
        S_RESULT = 4'd9,
        S_HOLD   = 4'd10
    } state_t;

    localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    state_t     next_state;
    logic [7:0] hold_cnt;
    logic       hold_last;
    logic       banker_draws;

    assign hold_last = (hold_cnt == HOLD_LAST);

    // Banker third-card table, evaluated with the two-card dealer score.
    always_comb begin
        banker_draws = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
            4'd3:             banker_draws = (pcard3 != 4'd8);
            4'd4:             banker_draws = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
            4'd5:             banker_draws = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
            4'd6:             banker_draws = (pcard3 == 4'd6) || (pcard3 == 4'd7);
            default:          banker_draws = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = S_PC1;
            S_PC1:    next_state = S_DC1;
            S_DC1:    next_state = S_PC2;
            S_PC2:    next_state = S_DC2;
            S_DC2:    next_state = S_NAT;
            S_NAT: begin
                // Illegal scores and naturals both settle immediately.
                if ((pscore > 4'd9) || (dscore > 4'd9))
                    next_state = S_RESULT;
                else if ((pscore >= 4'd8) || (dscore >= 4'd8))
                    next_state = S_RESULT;
                else if (pscore <= 4'd5)
                    next_state = S_PC3;
                else if (dscore <= 4'd5)
                    next_state = S_DC3;
                else
                    next_state = S_RESULT;
            end
            S_PC3:    next_state = S_BCHK;
            S_BCHK:   next_state = banker_draws ? S_DC3 : S_RESULT;
            S_DC3:    next_state = S_RESULT;
            S_RESULT: next_state = S_HOLD;
            S_HOLD: begin
                if (hold_last)
                    next_state = (AUTO_REPLAY != 0) ? S_PC1 : S_IDLE;
            end
            default:  next_state = S_IDLE;
        endcase
    end

    // Moore decodes straight from the state register, so an asynchronous
    // reset clears them without waiting for a clock edge.
    assign load_pcard1 = (state == S_PC1);
    assign load_pcard2 = (state == S_PC2);
    assign load_pcard3 = (state == S_PC3);
    assign load_dcard1 = (state == S_DC1);
    assign load_dcard2 = (state == S_DC2);
    assign load_dcard3 = (state == S_DC3);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_HOLD) && hold_last;

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            hold_cnt         <= 8'd0;
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
            player_wins      <= '0;
            dealer_wins      <= '0;
            ties             <= '0;
        end else begin
            state <= next_state;

            // Counter stays zero outside HOLD, so it is clear on HOLD entry.
            if (state == S_HOLD)
                hold_cnt <= hold_cnt + 8'd1;
            else
                hold_cnt <= 8'd0;

            if (state == S_RESULT) begin
                player_win_light <= (pscore >= dscore);
                dealer_win_light <= (pscore <= dscore);
                if (pscore > dscore) begin
                    if (~&player_wins) player_wins <= player_wins + CNT_ONE;
                end else if (pscore < dscore) begin
                    if (~&dealer_wins) dealer_wins <= dealer_wins + CNT_ONE;
                end else begin
                    if (~&ties) ties <= ties + CNT_ONE;
                end
            end else if ((next_state == S_PC1) && (state != S_PC1)) begin
                player_win_light <= 1'b0;
                dealer_win_light <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
